// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forward-source encoding,
// pipeline stage indices and multiply/divide opcodes.
package hazard_scoreboard_pkg;
    localparam int FWD_GRF = 0;
    localparam int STG_E   = 1;
    localparam int STG_M   = 2;
    localparam int STG_W   = 3;
    localparam int MD_OP_W = 2;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_op_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// HI/LO busy timer: loads a latency when a mult/div enters E, then counts
// down to zero. Reset aborts any operation in progress.
module md_busy_counter #(
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          busy_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller: a shift register of in-flight writers (E..W...)
// searched by D, E and M readers for the youngest matching destination.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int DEPTH   = 3,
    parameter int TW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         d_valid_i,
    input  logic [AW-1:0]                d_rs_i,
    input  logic [AW-1:0]                d_rt_i,
    input  logic                         d_rs_use_i,
    input  logic                         d_rt_use_i,
    input  logic [TW-1:0]                d_rs_tuse_i,
    input  logic [TW-1:0]                d_rt_tuse_i,
    input  logic [AW-1:0]                d_dst_i,
    input  logic [TW-1:0]                d_tnew_i,
    input  logic [1:0]                   d_md_op_i,
    input  logic                         d_md_use_i,
    input  logic                         d_eret_i,
    input  logic                         d_mtc0_epc_i,
    input  logic                         flush_i,
    output logic                         stall_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_d_rs_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_d_rt_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_e_rs_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_e_rt_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_m_rt_o,
    output logic                         md_busy_o
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(max2(MUL_LAT, DIV_LAT) + 1);

    typedef struct packed {
        logic               vld;
        logic [AW-1:0]      dst;
        logic [TW-1:0]      tnew;
        logic [AW-1:0]      rs;
        logic [AW-1:0]      rt;
        logic [MD_OP_W-1:0] md_op;
        logic               epc;
    } entry_t;

    typedef struct packed {
        logic          hit;
        logic [FW-1:0] k;
        logic [TW-1:0] tnew;
    } srch_t;

    // Youngest (lowest k >= kmin) valid writer of r; r == 0 never matches.
    function automatic srch_t search(input entry_t [DEPTH:1] e,
                                     input logic [AW-1:0] r, input int kmin);
        srch_t s;
        s = '0;
        for (int k = DEPTH; k >= 1; k--)
            if (k >= kmin && e[k].vld && e[k].dst == r && r != '0) begin
                s.hit  = 1'b1;
                s.k    = FW'(k);
                s.tnew = e[k].tnew;
            end
        return s;
    endfunction

    // A younger, not-yet-ready writer hides any older ready one.
    function automatic logic [FW-1:0] sel(input srch_t s);
        return (s.hit && s.tnew == '0) ? s.k : FW'(FWD_GRF);
    endfunction

    entry_t [DEPTH:1] ent_q;
    entry_t           new_ent;
    srch_t            s_drs, s_drt, s_ers, s_ert, s_mrt;
    logic             raw_stall, accept, md_busy;

    always_comb begin
        s_drs = search(ent_q, d_rs_i, STG_E);
        s_drt = search(ent_q, d_rt_i, STG_E);
        s_ers = search(ent_q, ent_q[STG_E].rs, STG_M);
        s_ert = search(ent_q, ent_q[STG_E].rt, STG_M);
        s_mrt = search(ent_q, ent_q[STG_M].rt, STG_W);

        raw_stall = d_valid_i & (
              (d_rs_use_i & s_drs.hit & (s_drs.tnew > d_rs_tuse_i))
            | (d_rt_use_i & s_drt.hit & (s_drt.tnew > d_rt_tuse_i))
            | (d_md_use_i & (md_busy | (ent_q[STG_E].vld & (ent_q[STG_E].md_op != MD_NONE))))
            | (d_eret_i & ((ent_q[STG_E].vld & ent_q[STG_E].epc)
                         | (ent_q[STG_M].vld & ent_q[STG_M].epc))));

        stall_o = raw_stall & ~flush_i;
        accept  = d_valid_i & ~raw_stall & ~flush_i;

        new_ent       = '0;
        new_ent.vld   = accept;
        new_ent.dst   = d_dst_i;
        new_ent.tnew  = d_tnew_i;
        new_ent.rs    = d_rs_i;
        new_ent.rt    = d_rt_i;
        new_ent.md_op = d_md_op_i;
        new_ent.epc   = d_mtc0_epc_i;
    end

    assign fwd_d_rs_o = sel(s_drs);
    assign fwd_d_rt_o = sel(s_drt);
    assign fwd_e_rs_o = ent_q[STG_E].vld ? sel(s_ers) : FW'(FWD_GRF);
    assign fwd_e_rt_o = ent_q[STG_E].vld ? sel(s_ert) : FW'(FWD_GRF);
    assign fwd_m_rt_o = ent_q[STG_M].vld ? sel(s_mrt) : FW'(FWD_GRF);
    assign md_busy_o  = md_busy;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        entry_t d, q;
        if (k == 1) begin : g_head
            assign d = new_ent;
        end else begin : g_body
            always_comb begin
                d      = ent_q[k-1];
                d.tnew = (ent_q[k-1].tnew != '0) ? ent_q[k-1].tnew - TW'(1) : '0;
                if (flush_i) d.vld = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) q <= '0;
            else         q <= d;
        end

        assign ent_q[k] = q;
    end

    md_busy_counter #(.CW(CW)) u_md_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (accept && d_md_op_i != MD_NONE),
        .load_val_i ((d_md_op_i == MD_DIV) ? CW'(DIV_LAT) : CW'(MUL_LAT)),
        .busy_o     (md_busy)
    );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: timestamp-based reference model, directed
// pipeline scenarios with literal expectations, then randomized traffic.
module tb_hazard_scoreboard;
    localparam int AW = 5, DEPTH = 3, TW = 2, MUL_LAT = 5, DIV_LAT = 10, FW = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic d_valid, d_rs_use, d_rt_use, d_md_use, d_eret, d_mtc0_epc, flush;
    logic [AW-1:0] d_rs, d_rt, d_dst;
    logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic [1:0] d_md_op;
    logic stall, md_busy;
    logic [FW-1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .TW(TW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .d_valid_i(d_valid), .d_rs_i(d_rs), .d_rt_i(d_rt),
        .d_rs_use_i(d_rs_use), .d_rt_use_i(d_rt_use), .d_rs_tuse_i(d_rs_tuse),
        .d_rt_tuse_i(d_rt_tuse), .d_dst_i(d_dst), .d_tnew_i(d_tnew), .d_md_op_i(d_md_op),
        .d_md_use_i(d_md_use), .d_eret_i(d_eret), .d_mtc0_epc_i(d_mtc0_epc), .flush_i(flush),
        .stall_o(stall), .fwd_d_rs_o(fwd_d_rs), .fwd_d_rt_o(fwd_d_rt), .fwd_e_rs_o(fwd_e_rs),
        .fwd_e_rt_o(fwd_e_rt), .fwd_m_rt_o(fwd_m_rt), .md_busy_o(md_busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: each accepted instruction is stamped with the cycle it
    // left D. At cycle c it sits in stage c-stamp, unless a flush came later.
    typedef struct { int dst; int tnew; int rs; int rt; int md_op; bit epc; } rec_t;
    rec_t acc[int];
    int cyc = 0, last_flush = -100, md_a = 0, md_L = 0;

    function automatic bit stage(input int k, output rec_t r);
        int a = cyc - k;
        r = '{default: 0};
        if (!acc.exists(a) || last_flush > a) return 0;
        r = acc[a];
        r.tnew = (r.tnew - (k - 1) > 0) ? r.tnew - (k - 1) : 0;
        return 1;
    endfunction

    function automatic int youngest(input int r, input int kmin, output int tn);
        rec_t e;
        tn = 0;
        for (int k = kmin; k <= DEPTH; k++)
            if (stage(k, e) && r != 0 && e.dst == r) begin
                tn = e.tnew;
                return k;
            end
        return 0;
    endfunction

    function automatic int fsel(input int r, input int kmin);
        int tn;
        int k = youngest(r, kmin, tn);
        return (k != 0 && tn == 0) ? k : 0;
    endfunction

    function automatic bit m_busy();
        return md_L > 0 && (cyc - md_a) >= 1 && (cyc - md_a) <= md_L;
    endfunction

    function automatic bit m_stall();
        rec_t e1, e2;
        bit v1, v2, s;
        int k, tn;
        s = 0;
        if (!d_valid || flush) return 0;
        v1 = stage(1, e1);
        v2 = stage(2, e2);
        if (d_rs_use) begin k = youngest(d_rs, 1, tn); if (k != 0 && tn > d_rs_tuse) s = 1; end
        if (d_rt_use) begin k = youngest(d_rt, 1, tn); if (k != 0 && tn > d_rt_tuse) s = 1; end
        if (d_md_use && (m_busy() || (v1 && e1.md_op != 0))) s = 1;
        if (d_eret && ((v1 && e1.epc) || (v2 && e2.epc))) s = 1;
        return s;
    endfunction

    function automatic int m_fwd_e(input bit use_rt);
        rec_t e;
        if (!stage(1, e)) return 0;
        return fsel(use_rt ? e.rt : e.rs, 2);
    endfunction

    function automatic int m_fwd_m();
        rec_t e;
        if (!stage(2, e)) return 0;
        return fsel(e.rt, 3);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc.delete();
            md_L = 0;
            last_flush = -100;
        end else begin
            if (d_valid && !flush && !m_stall()) begin
                acc[cyc] = '{dst: int'(d_dst), tnew: int'(d_tnew), rs: int'(d_rs),
                             rt: int'(d_rt), md_op: int'(d_md_op), epc: d_mtc0_epc};
                if (d_md_op != 0) begin
                    md_a = cyc;
                    md_L = (d_md_op == 2) ? DIV_LAT : MUL_LAT;
                end
            end
            if (flush) last_flush = cyc;
            if (acc.exists(cyc - DEPTH - 2)) acc.delete(cyc - DEPTH - 2);
            cyc++;
        end
    end

    always @(negedge clk) begin
        chk("stall",    stall,    m_stall());
        chk("fwd_d_rs", fwd_d_rs, fsel(d_rs, 1));
        chk("fwd_d_rt", fwd_d_rt, fsel(d_rt, 1));
        chk("fwd_e_rs", fwd_e_rs, m_fwd_e(0));
        chk("fwd_e_rt", fwd_e_rt, m_fwd_e(1));
        chk("fwd_m_rt", fwd_m_rt, m_fwd_m());
        chk("md_busy",  md_busy,  m_busy());
    end

    task automatic nop();
        d_valid = 0; d_rs = 0; d_rt = 0; d_rs_use = 0; d_rt_use = 0; d_rs_tuse = 0;
        d_rt_tuse = 0; d_dst = 0; d_tnew = 0; d_md_op = 0; d_md_use = 0; d_eret = 0;
        d_mtc0_epc = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_fdrs"}, fwd_d_rs, 0);
        chk({tag, "_fdrt"}, fwd_d_rt, 0);
        chk({tag, "_fers"}, fwd_e_rs, 0);
        chk({tag, "_fert"}, fwd_e_rt, 0);
        chk({tag, "_fmrt"}, fwd_m_rt, 0);
        chk({tag, "_busy"}, md_busy, 0);
    endtask

    task automatic rand_d();
        d_valid    = ($urandom_range(0, 3) != 0);
        d_rs       = AW'($urandom_range(0, 3));
        d_rt       = AW'($urandom_range(0, 3));
        d_rs_use   = $urandom_range(0, 1) == 1;
        d_rt_use   = $urandom_range(0, 1) == 1;
        d_rs_tuse  = TW'($urandom_range(0, 3));
        d_rt_tuse  = TW'($urandom_range(0, 3));
        d_dst      = AW'($urandom_range(0, 3));
        d_tnew     = TW'($urandom_range(0, 3));
        d_md_op    = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
        d_md_use   = ($urandom_range(0, 7) == 0);
        d_eret     = ($urandom_range(0, 7) == 0);
        d_mtc0_epc = ($urandom_range(0, 7) == 0);
        flush      = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        int n;
        nop();
        #1;
        all_zero("rst");
        #12 rst_n = 1'b1;
        tick();

        // load-use: lw $8 (tnew 2) then add $9,$8,$8 (tuse 1)
        d_valid = 1; d_dst = 8; d_tnew = 2;
        tick();
        nop(); d_valid = 1; d_rs = 8; d_rt = 8; d_rs_use = 1; d_rt_use = 1;
        d_rs_tuse = 1; d_rt_tuse = 1; d_dst = 9; d_tnew = 1;
        @(negedge clk); chk("s1_stall", stall, 1);
        tick();
        @(negedge clk); chk("s1_stall_clr", stall, 0); chk("s1_fdrs", fwd_d_rs, 0);
        tick();
        nop();
        @(negedge clk); chk("s1_fers", fwd_e_rs, 3); chk("s1_fert", fwd_e_rt, 3);
        drain();

        // addu $8 (tnew 1) then beq on $8 (tuse 0)
        d_valid = 1; d_dst = 8; d_tnew = 1;
        tick();
        nop(); d_valid = 1; d_rs = 8; d_rs_use = 1;
        @(negedge clk); chk("s2_stall", stall, 1);
        tick();
        @(negedge clk); chk("s2_stall_clr", stall, 0); chk("s2_fdrs", fwd_d_rs, 2);
        drain();

        // lw $8 at M (not ready), ori $8 at E (ready): youngest wins
        d_valid = 1; d_dst = 8; d_tnew = 2;
        tick();
        d_tnew = 0;
        tick();
        nop(); d_valid = 1; d_rs = 8; d_rs_use = 1;
        @(negedge clk); chk("s3_fdrs", fwd_d_rs, 1); chk("s3_stall", stall, 0);
        drain();

        // write to $0 is never a hazard
        d_valid = 1; d_dst = 0; d_tnew = 2;
        tick();
        nop(); d_valid = 1; d_rs_use = 1;
        @(negedge clk); chk("s6_fdrs", fwd_d_rs, 0); chk("s6_stall", stall, 0);
        drain();

        // div then mflo: stall for DIV_LAT cycles
        d_valid = 1; d_md_op = 2; d_md_use = 1;
        tick();
        nop(); d_valid = 1; d_md_use = 1; d_dst = 4;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            tick();
        end
        chk("s4_stall_cycles", n, 10);
        chk("s4_busy", md_busy, 0);
        tick();
        drain();

        // mtc0 EPC then eret: two stall cycles
        d_valid = 1; d_mtc0_epc = 1;
        tick();
        nop(); d_valid = 1; d_eret = 1;
        @(negedge clk); chk("s5_stall_e", stall, 1);
        tick();
        @(negedge clk); chk("s5_stall_m", stall, 1);
        tick();
        @(negedge clk); chk("s5_stall_w", stall, 0);
        drain();

        // same, with a flush during the interlock
        d_valid = 1; d_mtc0_epc = 1;
        tick();
        nop(); d_valid = 1; d_eret = 1;
        @(negedge clk); chk("s5f_stall", stall, 1);
        tick();
        flush = 1;
        @(negedge clk); chk("s5f_stall_flush", stall, 0);
        tick();
        flush = 0;
        @(negedge clk); all_zero("s5f_after");
        drain();

        for (int i = 0; i < 3000; i++) begin
            rand_d();
            tick();
        end

        // asynchronous reset in the middle of traffic
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 all_zero("mrst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            rand_d();
            tick();
        end
        nop();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
